vga_scan_render: RTL
====================

// Module: vga_scan_render
// PURPOSE
//  VGA timing generator and pixel renderer; the driving end of the pixel-query interface the
//  snake body block consumes. Produces xCount/yCount scan coordinates and the update (game-step)
//  tick. Accepts back the registered snakeHead/snakeBody/apple hit flags. Drives pipeline-aligned
//  hsync/vsync/RGB to the DAC.
// PARAMETERS
//  H_ACTIVE   640  visible pixels per line
//  H_FP       16   horizontal front porch (clocks)
//  H_SYNC     96   hsync pulse width (clocks)
//  H_BP       48   horizontal back porch (clocks)
//  V_ACTIVE   480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vsync pulse width (lines)
//  V_BP       33   vertical back porch (lines)
//  FRAME_DIV  4    frames per update pulse (>=1)
//  BORDER_W   10   wall thickness in pixels (used only with BORDER_EN)
// PORTS
//  VGA_clk      in   1   pixel clock (25.175 MHz nominal)
//  reset        in   1   asynchronous, active-high reset
//  snakeHead    in   1   head hit flag, registered 1 clk after xCount/yCount
//  snakeBody    in   1   body hit flag, registered 1 clk after xCount/yCount
//  apple        in   1   apple hit flag, registered 1 clk after xCount/yCount
//  xCount       out  10  current horizontal count, 0..H_TOTAL-1
//  yCount       out  10  current vertical count, 0..V_TOTAL-1
//  update       out  1   one-clock game-step pulse
//  border       out  1   wall hit flag for the pixel currently shown on RGB
//  VGA_hs       out  1   horizontal sync, active-low
//  VGA_vs       out  1   vertical sync, active-low
//  VGA_blank_n  out  1   high while the RGB pixel is in the visible area
//  VGA_R/G/B    out  4   colour per channel
// BEHAVIOUR
//  - H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
//  - xCount increments every clk. At H_TOTAL-1 it wraps to 0 and yCount increments.
//  - yCount wraps to 0 when it is V_TOTAL-1 and xCount is H_TOTAL-1.
//  - Stage 0 (counters): hs0 low for xCount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
//  - Stage 0: vs0 low for yCount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
//  - Stage 0: de0 = xCount<H_ACTIVE && yCount<V_ACTIVE.
//  - Stage 1 (flag align): hs0/vs0/de0 and x/y delayed 1 clk to match the returned hit flags.
//  - Stage 2 (output regs): VGA_hs/VGA_vs/VGA_blank_n/RGB/border registered.
//  - Total latency from xCount to pins is 2 clks. Sync, blank and colour stay mutually aligned.
//  - Colour priority, when de is high:
//      head    = F,F,0
//      body    = 0,F,0
//      apple   = F,0,0
//      border  = F,F,F
//      otherwise black (0,0,0)
//  - When de is low, RGB is forced to 0 regardless of the flags.
//  - Frame counter (0..FRAME_DIV-1) advances on the clk where xCount==0 && yCount==V_ACTIVE
//    (first clk of vertical blank).
//  - update=1 for exactly that one clk when the frame counter is FRAME_DIV-1; the counter then
//    wraps to 0. With FRAME_DIV=1, update pulses every frame.
//  - update runs unconditionally; game start/stop gating belongs to the consumer.
//  - Reset (any time, mid-line included) takes effect immediately:
//      xCount=0, yCount=0, frame counter=0, all pipeline regs cleared
//      update=0, border=0, RGB=0, VGA_blank_n=0, VGA_hs=1, VGA_vs=1
//  - After reset release, first valid hsync falls exactly H_ACTIVE+H_FP+2 clks later.
// CONFIGURATION
//  - BORDER_EN defined:
//      border=1 for displayed pixels with x<BORDER_W, x>=H_ACTIVE-BORDER_W, y<BORDER_W or
//      y>=V_ACTIVE-BORDER_W; computed from stage-1 coordinates and only while de.
//      A border pixel renders white unless head/body/apple win priority.
//  - BORDER_EN undefined: border tied 0; no wall comparators are synthesised.
// TESTING
//  - Reset held 5 clks, released -> xCount=1 one clk after release.
//    VGA_hs low first at clk 658 (=640+16+2), stays low 96 clks.
//  - Free-run 2 frames -> hsync period 800 clks; vsync low for 2 lines (1600 clks).
//    vsync period 420000 clks; yCount wraps 524->0.
//  - FRAME_DIV=4 -> update pulses 1 clk wide, every 1,680,000 clks, at xCount=0, yCount=480.
//  - Drive snakeHead=1 and snakeBody=1 one clk after xCount=100,yCount=50
//    -> RGB=F,F,0 exactly 2 clks after that xCount; body alone -> 0,F,0.
//  - Flags asserted while xCount=700 (blanking) -> RGB stays 0 and VGA_blank_n=0.
//  - BORDER_EN on: pixel (5,200) -> white, border=1; pixel (320,240) -> border=0.
//    Macro off -> border never 1.
//  - Assert reset mid-line at xCount=300 -> next clk all outputs at reset values;
//    timing restarts from 0 on release.

Source files
------------

// File: rtl/vga_scan_render.sv
// VGA scan counters, sync generation and two-stage pixel pipeline for the snake renderer.
// Optional wall rendering is built only when the BORDER_EN macro is defined.
module vga_scan_render #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int FRAME_DIV = 4,
  parameter int BORDER_W  = 10
) (
  input  logic       VGA_clk,
  input  logic       reset,
  input  logic       snakeHead,
  input  logic       snakeBody,
  input  logic       apple,
  output logic [9:0] xCount,
  output logic [9:0] yCount,
  output logic       update,
  output logic       border,
  output logic       VGA_hs,
  output logic       VGA_vs,
  output logic       VGA_blank_n,
  output logic [3:0] VGA_R,
  output logic [3:0] VGA_G,
  output logic [3:0] VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FC_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_ON  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_OFF = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_ON  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_OFF = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(FRAME_DIV - 1);

  logic            hs0, vs0, de0;
  logic            hs1, vs1, de1;
  logic            frame_tick;
  logic [FC_W-1:0] frame_cnt;
  logic            wall;
  logic [11:0]     rgb_next;

  // Stage 0: free-running scan position
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      xCount <= '0;
      yCount <= '0;
    end else if (xCount == H_LAST) begin
      xCount <= '0;
      if (yCount == V_LAST) yCount <= '0;
      else                  yCount <= yCount + 10'd1;
    end else begin
      xCount <= xCount + 10'd1;
    end
  end

  always_comb begin
    hs0 = !((xCount >= HS_ON) && (xCount <= HS_OFF));
    vs0 = !((yCount >= VS_ON) && (yCount <= VS_OFF));
    de0 = (xCount < H_VIS) && (yCount < V_VIS);
  end

  // Game-step divider, stepped once per frame on the first clock of vertical blank
  assign frame_tick = (xCount == 10'd0) && (yCount == V_VIS);
  assign update     = frame_tick && (frame_cnt == FC_LAST);

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
    end else if (frame_tick) begin
      if (frame_cnt == FC_LAST) frame_cnt <= '0;
      else                      frame_cnt <= frame_cnt + 1'b1;
    end
  end

  // Stage 1: timing delayed one clock so it lines up with the returned hit flags
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      hs1 <= 1'b1;
      vs1 <= 1'b1;
      de1 <= 1'b0;
    end else begin
      hs1 <= hs0;
      vs1 <= vs0;
      de1 <= de0;
    end
  end

`ifdef BORDER_EN
  localparam logic [9:0] BW   = 10'(BORDER_W);
  localparam logic [9:0] X_HI = 10'(H_ACTIVE - BORDER_W);
  localparam logic [9:0] Y_HI = 10'(V_ACTIVE - BORDER_W);

  logic [9:0] x1, y1;

  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      x1 <= '0;
      y1 <= '0;
    end else begin
      x1 <= xCount;
      y1 <= yCount;
    end
  end

  assign wall = de1 && ((x1 < BW) || (x1 >= X_HI) || (y1 < BW) || (y1 >= Y_HI));
`else
  assign wall = 1'b0;
`endif

  // Snake and apple sprites sit on top of the wall; blanking overrides everything
  always_comb begin
    rgb_next = 12'h000;
    if (de1) begin
      if (snakeHead)      rgb_next = 12'hFF0;
      else if (snakeBody) rgb_next = 12'h0F0;
      else if (apple)     rgb_next = 12'hF00;
      else if (wall)      rgb_next = 12'hFFF;
    end
  end

  // Stage 2: output registers keep sync, blank and colour mutually aligned
  always_ff @(posedge VGA_clk or posedge reset) begin
    if (reset) begin
      VGA_hs      <= 1'b1;
      VGA_vs      <= 1'b1;
      VGA_blank_n <= 1'b0;
      border      <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
    end else begin
      VGA_hs      <= hs1;
      VGA_vs      <= vs1;
      VGA_blank_n <= de1;
      border      <= wall;
      VGA_R       <= rgb_next[11:8];
      VGA_G       <= rgb_next[7:4];
      VGA_B       <= rgb_next[3:0];
    end
  end

endmodule
